// File: rtl/cp0_pkg.sv
// Shared CP0 register indices, exception codes and field positions.
// Used by cp0_exc_ctrl and cp0_timer (timer built only with CP0_TIMER_EN).
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_SYSCALL = 5'd8,
    EXC_BREAK   = 5'd9,
    EXC_TEQ     = 5'd13
  } exc_code_e;

  localparam int IE_BIT  = 0;
  localparam int IM_LSB  = 8;
  localparam int IP_LSB  = 8;
  localparam int EXC_LSB = 2;

  function automatic logic is_trap(input logic [4:0] c);
    return (c == EXC_SYSCALL) ||
           (c == EXC_BREAK) ||
           (c == EXC_TEQ);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// COUNT/COMPARE pair with a sticky compare-match interrupt.
// Instantiated by cp0_exc_ctrl only when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        tick
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
    end else if (ena) begin
      if (wr_en && addr == REG_COUNT)
        count <= data_in;
      else
        count <= count + 32'd1;
      // rewriting COMPARE is the only way to acknowledge the timer
      if (wr_en && addr == REG_COMPARE) begin
        compare <= data_in;
        tick    <= 1'b0;
      end else if (count == compare) begin
        tick    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: traps, masked IRQs, nested STATUS stack.
// Optional COUNT/COMPARE timer on IP[7] when CP0_TIMER_EN is defined.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter int          NEST_DEPTH = 3,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input  logic               cp0_clk,
  input  logic               cp0_rst,
  input  logic               cp0_ena,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic               eret,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc,
  input  logic [4:0]         addr,
  input  logic [31:0]        data_in,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        cp0_out,
  output logic [31:0]        pc_redirect,
  output logic               exc_take,
  output logic [2:0]         nest_lvl,
  output logic               nest_ovf
);

  logic [31:0] regs [32];
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] cause;
  logic [31:0] rd_data;
  logic [4:0]  excode;
  logic [7:0]  ip_q;
  logic [7:0]  ip_next;
  logic [7:0]  ip;
  logic        trap;
  logic        irq_pend;
  logic        take;
  logic        full;
  logic        do_mtc0;
  logic        wr_en;
  logic        hw_reg;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        tmr_tick;

  cp0_timer u_timer (
    .clk     (cp0_clk),
    .rst     (cp0_rst),
    .ena     (cp0_ena),
    .wr_en   (wr_en),
    .addr    (addr),
    .data_in (data_in),
    .count   (count),
    .compare (compare),
    .tick    (tmr_tick)
  );
`endif

  always_comb begin
    ip_next = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      ip_next[i] = irq[i];
    ip = ip_q;
`ifdef CP0_TIMER_EN
    ip[7] = tmr_tick;
`endif
  end

  assign trap     = exc_req & is_trap(exc_code);
  assign irq_pend = status[IE_BIT] &
                    (|(status[IM_LSB +: 8] & ip));
  assign take     = trap | irq_pend;
  assign full     = (nest_lvl == 3'(NEST_DEPTH));
  assign do_mtc0  = mtc0 & ~take & ~eret;
  assign wr_en    = cp0_ena & do_mtc0;

  // indices with dedicated state never land in the plain array
  assign hw_reg = (addr == REG_STATUS) || (addr == REG_CAUSE) ||
                  (addr == REG_EPC) || (addr == REG_COUNT) ||
                  (addr == REG_COMPARE);

  always_ff @(negedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      status   <= '0;
      epc      <= '0;
      excode   <= '0;
      ip_q     <= '0;
      nest_lvl <= '0;
      exc_take <= 1'b0;
      nest_ovf <= 1'b0;
    end else if (!cp0_ena) begin
      exc_take <= 1'b0;
    end else begin
      ip_q     <= ip_next;
      exc_take <= 1'b0;
      if (take) begin
        if (full) begin
          nest_ovf <= 1'b1;
        end else begin
          status   <= status << 5;
          excode   <= trap ? exc_code : 5'(EXC_INT);
          epc      <= trap ? pc + 32'd4 : pc;
          nest_lvl <= nest_lvl + 3'd1;
          exc_take <= 1'b1;
        end
      end else if (eret) begin
        status <= status >> 5;
        if (nest_lvl != 3'd0)
          nest_lvl <= nest_lvl - 3'd1;
      end else if (do_mtc0) begin
        case (addr)
          REG_STATUS: begin
            status   <= data_in;
            nest_ovf <= 1'b0;
          end
          REG_CAUSE: excode <= data_in[EXC_LSB +: 5];
          REG_EPC:   epc    <= data_in;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(negedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_en && !hw_reg) begin
      regs[addr] <= data_in;
    end
  end

  always_comb begin
    cause = '0;
    cause[IP_LSB +: 8]  = ip;
    cause[EXC_LSB +: 5] = excode;
  end

  always_comb begin
    case (addr)
      REG_STATUS:  rd_data = status;
      REG_CAUSE:   rd_data = cause;
      REG_EPC:     rd_data = epc;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
`else
      REG_COUNT:   rd_data = '0;
      REG_COMPARE: rd_data = '0;
`endif
      default:     rd_data = regs[addr];
    endcase
  end

  assign cp0_out     = (mfc0 & cp0_ena) ? rd_data : 32'h0;
  assign pc_redirect = (eret & cp0_ena) ? epc : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl (default parameters).
// Timer scenario compiled in only with CP0_TIMER_EN.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        mfc0;
  logic        mtc0;
  logic        eret;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] pc;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [5:0]  irq;
  logic [31:0] cp0_out;
  logic [31:0] pc_redirect;
  logic        exc_take;
  logic [2:0]  nest_lvl;
  logic        nest_ovf;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  cp0_exc_ctrl dut (
    .cp0_clk     (clk),
    .cp0_rst     (rst),
    .cp0_ena     (ena),
    .mfc0        (mfc0),
    .mtc0        (mtc0),
    .eret        (eret),
    .exc_req     (exc_req),
    .exc_code    (exc_code),
    .pc          (pc),
    .addr        (addr),
    .data_in     (data_in),
    .irq         (irq),
    .cp0_out     (cp0_out),
    .pc_redirect (pc_redirect),
    .exc_take    (exc_take),
    .nest_lvl    (nest_lvl),
    .nest_ovf    (nest_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    mtc0 = 0; eret = 0; exc_req = 0;
    exc_code = 0; mfc0 = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    mfc0 = 1; addr = a;
    #1;
    v = cp0_out;
    mfc0 = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    mtc0 = 1; addr = a; data_in = v;
    tick();
    mtc0 = 0;
  endtask

  task automatic do_reset();
    idle();
    ena = 1; pc = 0; addr = 0; data_in = 0; irq = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (exc_take !== 1'b0) begin errors++;
      $display("FAIL rst_take got=%0b want=0", exc_take); end
    checks++; if (nest_lvl !== 3'd0) begin errors++;
      $display("FAIL rst_lvl got=%0d want=0", nest_lvl); end
    checks++; if (nest_ovf !== 1'b0) begin errors++;
      $display("FAIL rst_ovf got=%0b want=0", nest_ovf); end
    checks++; if (pc_redirect !== 32'h00400004) begin errors++;
      $display("FAIL rst_redir got=%h want=00400004", pc_redirect); end
    rd(12, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL rst_status got=%h want=0", d); end
  endtask

  task automatic test_irq();
    do_reset();
    irq = 6'b000100;
    pc = 32'h00400200;
    wr(12, 32'h0000FF01);
    checks++; if (exc_take !== 1'b0) begin errors++;
      $display("FAIL irq_early got=%0b want=0", exc_take); end
    tick();
    checks++; if (exc_take !== 1'b1) begin errors++;
      $display("FAIL irq_take got=%0b want=1", exc_take); end
    checks++; if (nest_lvl !== 3'd1) begin errors++;
      $display("FAIL irq_lvl got=%0d want=1", nest_lvl); end
    rd(14, d);
    checks++; if (d !== 32'h00400200) begin errors++;
      $display("FAIL irq_epc got=%h want=00400200", d); end
    rd(13, d);
    checks++; if (d !== 32'h00000400) begin errors++;
      $display("FAIL irq_cause got=%h want=00000400", d); end
    rd(12, d);
    checks++; if (d !== 32'h001FE020) begin errors++;
      $display("FAIL irq_status got=%h want=001FE020", d); end
    tick();
    checks++; if (exc_take !== 1'b0) begin errors++;
      $display("FAIL irq_pulse got=%0b want=0", exc_take); end
  endtask

  task automatic test_trap_eret();
    do_reset();
    wr(12, 32'h0000FF01);
    pc = 32'h00400100; exc_req = 1; exc_code = 8;
    tick();
    idle();
    checks++; if (exc_take !== 1'b1) begin errors++;
      $display("FAIL trap_take got=%0b want=1", exc_take); end
    checks++; if (nest_lvl !== 3'd1) begin errors++;
      $display("FAIL trap_lvl got=%0d want=1", nest_lvl); end
    rd(14, d);
    checks++; if (d !== 32'h00400104) begin errors++;
      $display("FAIL trap_epc got=%h want=00400104", d); end
    rd(13, d);
    checks++; if (d !== 32'h00000020) begin errors++;
      $display("FAIL trap_cause got=%h want=00000020", d); end
    eret = 1;
    #1;
    checks++; if (pc_redirect !== 32'h00400104) begin errors++;
      $display("FAIL eret_redir got=%h want=00400104", pc_redirect); end
    tick();
    checks++; if (nest_lvl !== 3'd0) begin errors++;
      $display("FAIL eret_lvl got=%0d want=0", nest_lvl); end
    rd(12, d);
    checks++; if (d !== 32'h0000FF01) begin errors++;
      $display("FAIL eret_status got=%h want=0000FF01", d); end
    eret = 1;
    tick();
    eret = 0;
    checks++; if (nest_lvl !== 3'd0) begin errors++;
      $display("FAIL eret0_lvl got=%0d want=0", nest_lvl); end
    rd(12, d);
    checks++; if (d !== 32'h000007F8) begin errors++;
      $display("FAIL eret0_status got=%h want=000007F8", d); end
    exc_req = 1; exc_code = 5;
    tick();
    idle();
    checks++; if (exc_take !== 1'b0 || nest_lvl !== 3'd0) begin
      errors++;
      $display("FAIL bad_code take=%0b lvl=%0d want 0/0",
               exc_take, nest_lvl);
    end
  endtask

  task automatic test_nest();
    logic [31:0] st [4];
    logic [31:0] ep [4];
    st = '{32'h60, 32'hC00, 32'h18000, 32'h18000};
    ep = '{32'h104, 32'h204, 32'h304, 32'h304};
    do_reset();
    wr(12, 32'h00000003);
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 * (i + 1);
      exc_req = 1; exc_code = 9;
      tick();
      idle();
      checks++; if (exc_take !== (i < 3)) begin errors++;
        $display("FAIL nest%0d_take got=%0b want=%0b",
                 i, exc_take, i < 3); end
      checks++; if (nest_lvl !== 3'((i < 3) ? i + 1 : 3)) begin
        errors++;
        $display("FAIL nest%0d_lvl got=%0d", i, nest_lvl); end
      rd(14, d);
      checks++; if (d !== ep[i]) begin errors++;
        $display("FAIL nest%0d_epc got=%h want=%h", i, d, ep[i]); end
      rd(12, d);
      checks++; if (d !== st[i]) begin errors++;
        $display("FAIL nest%0d_st got=%h want=%h", i, d, st[i]); end
    end
    checks++; if (nest_ovf !== 1'b1) begin errors++;
      $display("FAIL nest_ovf got=%0b want=1", nest_ovf); end
    wr(12, 32'h0);
    checks++; if (nest_ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clear got=%0b want=0", nest_ovf); end
  endtask

  task automatic test_priority();
    do_reset();
    irq = 6'b000001;
    wr(12, 32'h0000FF01);
    pc = 32'h00400500;
    exc_req = 1; exc_code = 13;
    mtc0 = 1; addr = 20; data_in = 32'hDEADBEEF;
    tick();
    idle();
    checks++; if (exc_take !== 1'b1) begin errors++;
      $display("FAIL prio_take got=%0b want=1", exc_take); end
    rd(13, d);
    checks++; if (d !== 32'h00000134) begin errors++;
      $display("FAIL prio_cause got=%h want=00000134", d); end
    rd(14, d);
    checks++; if (d !== 32'h00400504) begin errors++;
      $display("FAIL prio_epc got=%h want=00400504", d); end
    rd(20, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL prio_drop got=%h want=0", d); end
    eret = 1;
    tick();
    eret = 0;
    pc = 32'h00400600;
    tick();
    checks++; if (exc_take !== 1'b1 || nest_lvl !== 3'd1) begin
      errors++;
      $display("FAIL prio_irq take=%0b lvl=%0d want 1/1",
               exc_take, nest_lvl);
    end
    rd(13, d);
    checks++; if (d !== 32'h00000100) begin errors++;
      $display("FAIL prio_irq_cause got=%h want=00000100", d); end
    rd(14, d);
    checks++; if (d !== 32'h00400600) begin errors++;
      $display("FAIL prio_irq_epc got=%h want=00400600", d); end
  endtask

  task automatic test_mtc0();
    do_reset();
    wr(20, 32'hA5A51234);
    wr(13, 32'hFFFFFFFF);
    wr(9, 32'h12345678);
    rd(20, d);
    checks++; if (d !== 32'hA5A51234) begin errors++;
      $display("FAIL mtc0_store got=%h want=A5A51234", d); end
    rd(13, d);
    checks++; if (d !== 32'h0000007C) begin errors++;
      $display("FAIL mtc0_cause got=%h want=0000007C", d); end
`ifndef CP0_TIMER_EN
    rd(9, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL mtc0_count got=%h want=0", d); end
`endif
    ena = 0;
    wr(20, 32'h0);
    rd(20, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL dis_out got=%h want=0", d); end
    wr(14, 32'h11112222);
    eret = 1;
    #1;
    checks++; if (pc_redirect !== 32'h00400004) begin errors++;
      $display("FAIL dis_redir got=%h want=00400004", pc_redirect); end
    ena = 1;
    #1;
    checks++; if (pc_redirect !== 32'h0) begin errors++;
      $display("FAIL en_redir got=%h want=0", pc_redirect); end
    eret = 0;
    rd(20, d);
    checks++; if (d !== 32'hA5A51234) begin errors++;
      $display("FAIL dis_hold got=%h want=A5A51234", d); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    do_reset();
    wr(11, 32'd5);
    for (int i = 0; i < 5; i++) begin
      rd(13, d);
      checks++; if (d[15] !== 1'b0) begin errors++;
        $display("FAIL tmr_early%0d got=%0b want=0", i, d[15]); end
      tick();
    end
    rd(13, d);
    checks++; if (d[15] !== 1'b1) begin errors++;
      $display("FAIL tmr_hit got=%0b want=1", d[15]); end
    rd(9, d);
    checks++; if (d !== 32'd6) begin errors++;
      $display("FAIL tmr_count got=%0d want=6", d); end
    wr(11, 32'd100);
    rd(13, d);
    checks++; if (d[15] !== 1'b0) begin errors++;
      $display("FAIL tmr_ack got=%0b want=0", d[15]); end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    pc = 32'h00400100; exc_req = 1; exc_code = 8;
    tick();
    idle();
    checks++; if (exc_take !== 1'b1) begin errors++;
      $display("FAIL ar_pre got=%0b want=1", exc_take); end
    #1;
    rst = 1;
    #1;
    checks++; if (exc_take !== 1'b0 || nest_lvl !== 3'd0 ||
                  nest_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ar_outs take=%0b lvl=%0d ovf=%0b want 0",
               exc_take, nest_lvl, nest_ovf);
    end
    checks++; if (pc_redirect !== 32'h00400004) begin errors++;
      $display("FAIL ar_redir got=%h want=00400004", pc_redirect); end
    rd(14, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL ar_epc got=%h want=0", d); end
    tick();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_irq();
    test_trap_eret();
    test_nest();
    test_priority();
    test_mtc0();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Parametrised coprocessor-0 exception controller for the single-cycle MIPS core.
- Handles synchronous traps (SYSCALL/BREAK/TEQ) and NUM_IRQ masked hardware interrupts.
- Keeps a nested STATUS shift-stack of NEST_DEPTH levels and supports MFC0/MTC0/ERET.
- Supplies the PC redirect target and a one-cycle exception-taken pulse to the fetch stage.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..8), mapped to CAUSE.IP[7:0] / STATUS.IM[7:0].
- NEST_DEPTH, 3, maximum nested exception levels (1..6); STATUS shifts 5 bits per level.
- EXC_VECTOR, 32'h00400004, handler entry address.

Ports:
- cp0_clk  in  1  clock; all state updates on falling edge.
- cp0_rst  in  1  reset, asynchronous, active-high.
- cp0_ena  in  1  global enable; when low, state holds and outputs take their disabled values.
- mfc0  in  1  read request.
- mtc0  in  1  write request.
- eret  in  1  return from exception.
- exc_req  in  1  synchronous trap request.
- exc_code  in  5  trap cause: 8 SYSCALL, 9 BREAK, 13 TEQ.
- pc  in  32  PC of the current instruction.
- addr  in  5  CP0 register index.
- data_in  in  32  MTC0 write data.
- irq  in  NUM_IRQ  level-sensitive interrupt lines.
- cp0_out  out  32  MFC0 read data.
- pc_redirect  out  32  eret ? EPC : EXC_VECTOR.
- exc_take  out  1  registered pulse: exception/interrupt accepted on the last edge.
- nest_lvl  out  3  current nesting depth.
- nest_ovf  out  1  sticky: event rejected because the stack was full.

Behaviour:
- Registers:
  - STATUS(12): bit0 IE, [15:8] IM.
  - CAUSE(13): [6:2] ExcCode, [15:8] IP.
  - EPC(14).
  - COUNT(9) and COMPARE(11), only under the optional feature.
  - All other indices are storage-only.
- Reset: all registers, nest_lvl, exc_take and nest_ovf clear to 0; reset applies regardless of cp0_ena.
- cp0_out: combinational; cp0_reg[addr] when mfc0 & cp0_ena, else 32'h0.
- pc_redirect: combinational; EPC when eret & cp0_ena, else EXC_VECTOR.
- IP capture: CAUSE.IP[NUM_IRQ-1:0] samples irq every enabled edge; bits above NUM_IRQ read 0 (bit 7 excepted under the timer feature).
- Interrupt eligibility: irq_pend = IE & |(IM & IP).
- Event priority per edge, exactly one acts:
  1. Valid exc_req: code is 8, 9 or 13; any other code is ignored.
  2. irq_pend.
  3. eret.
  4. mtc0.
- Taking an event when nest_lvl < NEST_DEPTH:
  - STATUS <= STATUS << 5.
  - CAUSE.ExcCode <= exc_code for a trap, 0 for an interrupt.
  - EPC <= pc+4 for a trap, pc for an interrupt.
  - nest_lvl increments; exc_take = 1 for one cycle.
- Taking an event when nest_lvl == NEST_DEPTH: no state change except nest_ovf <= 1; exc_take stays 0.
- ERET: STATUS <= STATUS >> 5 and nest_lvl decrements. At nest_lvl 0, STATUS still shifts but nest_lvl stays 0 (no underflow).
- MTC0: writes data_in to cp0_reg[addr]. A write to index 13 only changes ExcCode; IP is hardware-owned. nest_ovf clears on any MTC0 to STATUS.
- An MTC0 in the same cycle as a higher-priority event is dropped.
- Reset mid-sequence: asynchronous clear; exc_take drops immediately.

Optional Feature:
- Macro: CP0_TIMER_EN.
- With it:
  - COUNT increments by 1 each enabled edge and wraps at 2^32.
  - When COUNT == COMPARE, CAUSE.IP[7] sets and stays set until an MTC0 writes COMPARE.
  - An MTC0 to COUNT overrides that edge's increment.
- Without it: indices 9 and 11 read 0 and ignore writes; IP[7] comes from irq only when NUM_IRQ = 8.

Decomposition:
- Package cp0_pkg:
  - Register index constants STATUS/CAUSE/EPC/COUNT/COMPARE.
  - Exception code constants SYSCALL/BREAK/TEQ/INT.
  - Field bit positions IE, IM, IP, ExcCode.
- Sub-module cp0_timer: COUNT/COMPARE, instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset, MTC0 STATUS=32'h0000FF01, irq=6'b000100 -> next edge:
   - exc_take=1, EPC=pc, CAUSE=32'h00000400.
   - STATUS=32'h001FE020, nest_lvl=1.
2. pc=32'h00400100, exc_req with code 8 -> EPC=32'h00400104, CAUSE[6:2]=8, nest_lvl=1. Then ERET -> pc_redirect=32'h00400104, STATUS restored, nest_lvl=0.
3. NEST_DEPTH=3, four back-to-back BREAK traps:
   - nest_lvl saturates at 3; the 4th has exc_take=0 and sets nest_ovf=1.
   - EPC unchanged by the 4th.
4. exc_req code 13, irq_pend and mtc0 all in one cycle -> trap taken, ExcCode=13; MTC0 write absent; interrupt taken on the following edge.
5. With CP0_TIMER_EN, COMPARE=5 after reset -> IP[7]=1 when COUNT reaches 5. MTC0 COMPARE=100 -> IP[7]=0 on the next edge.
6. Assert cp0_rst asynchronously while exc_take=1 -> all outputs 0 immediately; pc_redirect=32'h00400004.
